// File: rtl/bytebeat_pkg.sv
// Shared types and constants for the bytebeat audio back end.
// Midscale value, output-mode encoding and the channel-count log2 helper.
package bytebeat_pkg;

  localparam int unsigned SAMPLE_W_DEF = 8;
  localparam logic [SAMPLE_W_DEF-1:0] SAMPLE_MID = SAMPLE_W_DEF'(1) << (SAMPLE_W_DEF - 1);

  typedef enum logic {
    MIX_INDEP = 1'b0,
    MIX_MONO  = 1'b1
  } mix_mode_t;

  function automatic int unsigned sample_mid(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned clog2_ch(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bytebeat_voice_mixer_pwm_cmp_slice.sv
// One PWM channel: compare register loaded at the period wrap, registered output.
module pwm_cmp_slice #(
  parameter int unsigned     PWM_W   = 8,
  parameter logic [PWM_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             load,
  input  logic [PWM_W-1:0] value,
  output logic             pwm
);

  logic [PWM_W-1:0] cmp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp <= RST_VAL;
      pwm <= 1'b0;
    end else begin
      if (load) cmp <= value;
      pwm <= (pwm_cnt < cmp);
    end
  end

endmodule

// File: rtl/bytebeat_voice_mixer.sv
// N-channel audio back end: sample-rate tick, valid/ready capture with underrun
// flags, averaging mixer, and per-channel or mixed-mono PWM outputs.
module bytebeat_voice_mixer
  import bytebeat_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned DIV_W    = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DIV_W-1:0]             tick_div,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic                         mix_mode,
  input  logic                         clr_status,
  input  logic [NUM_CH*SAMPLE_W-1:0]   pcm_data,
  input  logic [NUM_CH-1:0]            pcm_vld,
  output logic [NUM_CH-1:0]            pcm_rdy,
  output logic                         sample_tick,
  output logic [NUM_CH-1:0]            pwm_out,
  output logic [NUM_CH-1:0]            underrun
);

  localparam int unsigned LOG   = clog2_ch(NUM_CH);
  localparam int unsigned SUM_W = SAMPLE_W + LOG;
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(sample_mid(SAMPLE_W));

  logic [DIV_W-1:0]    tick_cnt, tick_cnt_next;
  logic [SAMPLE_W-1:0] sample_reg [NUM_CH];
  logic [SAMPLE_W-1:0] mix;
  logic [SUM_W-1:0]    sum;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [NUM_CH-1:0]   starve;
  logic                wrap;
  mix_mode_t           mode_q, mode_next;

  // Tick is registered against the next count so it reads 0 out of reset,
  // yet still coincides with tick_cnt == tick_div in normal running.
  assign tick_cnt_next = (tick_cnt == tick_div) ? '0 : tick_cnt + DIV_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else begin
      tick_cnt    <= tick_cnt_next;
      sample_tick <= (tick_cnt_next == tick_div);
    end
  end

  assign pcm_rdy = {NUM_CH{sample_tick}} & ch_en;
  assign starve  = {NUM_CH{sample_tick}} & ch_en & ~pcm_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) sample_reg[i] <= MID;
      underrun <= '0;
    end else begin
      underrun <= (clr_status ? '0 : underrun) | starve;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sample_tick) begin
          if (!ch_en[i])
            sample_reg[i] <= MID;
          else if (pcm_vld[i])
            sample_reg[i] <= pcm_data[i*SAMPLE_W +: SAMPLE_W];
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) sum = sum + SUM_W'(sample_reg[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) mix <= MID;
    else        mix <= SAMPLE_W'(sum >> LOG);
  end

  assign wrap      = (pwm_cnt == '1);
  assign mode_next = wrap ? mix_mode_t'(mix_mode) : mode_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      mode_q  <= MIX_INDEP;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      mode_q  <= mode_next;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
    logic [PWM_W-1:0] value;
    if (g == 0) begin : g_head
      assign value = (mode_next == MIX_MONO) ? mix[SAMPLE_W-1 -: PWM_W]
                                             : sample_reg[g][SAMPLE_W-1 -: PWM_W];
    end else begin : g_rest
      assign value = (mode_next == MIX_MONO) ? '0 : sample_reg[g][SAMPLE_W-1 -: PWM_W];
    end

    pwm_cmp_slice #(
      .PWM_W   (PWM_W),
      .RST_VAL (MID[SAMPLE_W-1 -: PWM_W])
    ) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .pwm_cnt (pwm_cnt),
      .load    (wrap),
      .value   (value),
      .pwm     (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_bytebeat_voice_mixer.sv
// Randomized self-checking bench for bytebeat_voice_mixer; PWM behaviour is
// checked as duty counts over whole 256-cycle windows against a voice model.
module tb_bytebeat_voice_mixer;

  localparam int NC = 8;
  localparam int SW = 8;
  localparam int DW = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     tick_div = 9'd3;
  logic [NC-1:0]     ch_en = '0;
  logic              mix_mode = 1'b0;
  logic              clr_status = 1'b0;
  logic [NC*SW-1:0]  pcm_data = '0;
  logic [NC-1:0]     pcm_vld = '0;
  logic [NC-1:0]     pcm_rdy;
  logic              sample_tick;
  logic [NC-1:0]     pwm_out;
  logic [NC-1:0]     underrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] data     [NC];
  logic [7:0] voice    [NC];
  int         duty     [NC];

  bytebeat_voice_mixer #(
    .NUM_CH   (NC),
    .SAMPLE_W (SW),
    .PWM_W    (8),
    .DIV_W    (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_div    (tick_div),
    .ch_en       (ch_en),
    .mix_mode    (mix_mode),
    .clr_status  (clr_status),
    .pcm_data    (pcm_data),
    .pcm_vld     (pcm_vld),
    .pcm_rdy     (pcm_rdy),
    .sample_tick (sample_tick),
    .pwm_out     (pwm_out),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic apply_data();
    for (int i = 0; i < NC; i++) pcm_data[i*SW +: SW] = data[i];
  endtask

  // What each voice holds once a tick has seen the current inputs.
  task automatic model_capture();
    for (int i = 0; i < NC; i++) begin
      if (!ch_en[i])      voice[i] = 8'h80;
      else if (pcm_vld[i]) voice[i] = data[i];
    end
  endtask

  function automatic int exp_duty(input int ch);
    int s;
    if (!mix_mode) return int'(voice[ch]);
    if (ch != 0) return 0;
    s = 0;
    for (int i = 0; i < NC; i++) s += int'(voice[i]);
    return s / NC;
  endfunction

  task automatic wait_tick(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sample_tick && k < 1000);
    if (!sample_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no sample_tick within %0d cycles", k);
    end
  endtask

  // Leaves the bench at the negedge where tick_cnt has just wrapped to 0.
  task automatic sync_tick();
    int k;
    wait_tick(k);
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (300) @(negedge clk);
  endtask

  task automatic measure();
    for (int i = 0; i < NC; i++) duty[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) if (pwm_out[i]) duty[i]++;
    end
  endtask

  task automatic test_reset();
    int k;
    rst_n = 1'b0;
    tick_div = 9'd3;
    for (int i = 0; i < NC; i++) data[i] = 8'h00;
    apply_data();
    repeat (3) @(negedge clk);
    checks++;
    if (sample_tick !== 1'b0 || pwm_out !== '0 || underrun !== '0 || pcm_rdy !== '0) begin
      errors++;
      $display("FAIL reset_state: tick=%b pwm=%h underrun=%h rdy=%h, need all 0",
               sample_tick, pwm_out, underrun, pcm_rdy);
    end
    rst_n = 1'b1;
    wait_tick(k);
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL reset_first_tick: got %0d cycles, need 3", k);
    end
    for (int i = 0; i < NC; i++) voice[i] = 8'h80;
  endtask

  task automatic test_tick_period();
    int k;
    int d;
    for (int n = 0; n < 5; n++) begin
      wait_tick(k);
      checks++;
      if (k !== 4) begin
        errors++;
        $display("FAIL tick_div3_gap: got %0d, need 4", k);
      end
    end
    repeat (4) begin
      d = $urandom_range(1, 40);
      sync_tick();
      tick_div = DW'(d);
      wait_tick(k);
      checks++;
      if (k !== d) begin
        errors++;
        $display("FAIL tick_first_gap div=%0d: got %0d, need %0d", d, k, d);
      end
      wait_tick(k);
      checks++;
      if (k !== d + 1) begin
        errors++;
        $display("FAIL tick_period div=%0d: got %0d, need %0d", d, k, d + 1);
      end
    end
    sync_tick();
    tick_div = '0;
    k = 0;
    repeat (20) begin
      @(negedge clk);
      if (sample_tick) k++;
    end
    checks++;
    if (k !== 20) begin
      errors++;
      $display("FAIL tick_div0: high %0d of 20 cycles, need 20", k);
    end
    // Lowering tick_div below the running count must ride through the overflow.
    tick_div = 9'd20;
    wait_tick(k);
    repeat (11) @(negedge clk);
    tick_div = 9'd3;
    wait_tick(k);
    checks++;
    if (k !== 505) begin
      errors++;
      $display("FAIL tick_overflow_wrap: got %0d cycles, need 505", k);
    end
    sync_tick();
    tick_div = 9'd1;
  endtask

  task automatic test_capture_pwm();
    mix_mode = 1'b0;
    ch_en = '1;
    pcm_vld = '1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NC; i++) data[i] = 8'($urandom);
      if (r == 0) begin
        data[0] = 8'h40;
        data[1] = 8'h00;
        data[2] = 8'hFF;
      end
      apply_data();
      settle();
      model_capture();
      measure();
      for (int i = 0; i < NC; i++) begin
        checks++;
        if (duty[i] !== exp_duty(i)) begin
          errors++;
          $display("FAIL capture_duty r%0d ch%0d: got %0d, need %0d", r, i, duty[i], exp_duty(i));
        end
      end
    end
  endtask

  task automatic test_underrun();
    int k;
    mix_mode = 1'b0;
    ch_en = '1;
    pcm_vld = '1;
    for (int i = 0; i < NC; i++) data[i] = 8'($urandom);
    apply_data();
    settle();
    model_capture();
    ch_en = 8'hDF;
    pcm_vld = 8'hD7;
    data[3] = ~data[3];
    apply_data();
    wait_tick(k);
    checks++;
    if (pcm_rdy !== 8'hDF) begin
      errors++;
      $display("FAIL rdy_at_tick: got %h, need df", pcm_rdy);
    end
    @(negedge clk);
    checks++;
    if (underrun !== 8'h08) begin
      errors++;
      $display("FAIL underrun_set: got %h, need 08", underrun);
    end
    checks++;
    if (pcm_rdy !== 8'h00) begin
      errors++;
      $display("FAIL rdy_off_tick: got %h, need 00", pcm_rdy);
    end
    settle();
    model_capture();
    measure();
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (duty[i] !== exp_duty(i)) begin
        errors++;
        $display("FAIL underrun_hold ch%0d: got %0d, need %0d", i, duty[i], exp_duty(i));
      end
    end
    wait_tick(k);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++;
    if (underrun[3] !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_set: got %b, need 1", underrun[3]);
    end
    pcm_vld = '1;
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++;
    if (underrun !== 8'h00) begin
      errors++;
      $display("FAIL clear_alone: got %h, need 00", underrun);
    end
  endtask

  task automatic test_mix_mode();
    int k;
    logic leak;
    mix_mode = 1'b1;
    ch_en = 8'h01;
    pcm_vld = '1;
    for (int i = 0; i < NC; i++) data[i] = 8'h11;
    data[0] = 8'hFF;
    apply_data();
    settle();
    model_capture();
    measure();
    checks++;
    if (duty[0] !== 143) begin
      errors++;
      $display("FAIL mono_duty ch0: got %0d, need 143", duty[0]);
    end
    for (int i = 1; i < NC; i++) begin
      checks++;
      if (duty[i] !== 0) begin
        errors++;
        $display("FAIL mono_silent ch%0d: got %0d, need 0", i, duty[i]);
      end
    end
    // Rising edge of the mono output marks the start of a PWM period.
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(pwm_out[0] && k > 1) && k < 600);
    while (pwm_out[0] && k < 600) begin
      @(negedge clk);
      k++;
    end
    while (!pwm_out[0] && k < 600) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 600) begin
      errors++;
      $display("FAIL period_sync: no rising edge within %0d cycles", k);
    end
    mix_mode = 1'b0;
    leak = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (pwm_out[NC-1:1] !== '0) leak = 1'b1;
    end
    mix_mode = 1'b1;
    checks++;
    if (leak !== 1'b0) begin
      errors++;
      $display("FAIL mode_glitch: other channels active=%b, need 0", leak);
    end
    measure();
    checks++;
    if (duty[0] !== 143 || duty[1] !== 0) begin
      errors++;
      $display("FAIL mode_toggle_duty: ch0=%0d ch1=%0d, need 143 0", duty[0], duty[1]);
    end
    for (int r = 0; r < 3; r++) begin
      ch_en = 8'($urandom);
      for (int i = 0; i < NC; i++) data[i] = 8'($urandom);
      apply_data();
      settle();
      model_capture();
      measure();
      for (int i = 0; i < NC; i++) begin
        checks++;
        if (duty[i] !== exp_duty(i)) begin
          errors++;
          $display("FAIL mix_random r%0d ch%0d en=%h: got %0d, need %0d",
                   r, i, ch_en, duty[i], exp_duty(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    mix_mode = 1'b0;
    ch_en = '1;
    pcm_vld = '1;
    sync_tick();
    tick_div = 9'd3;
    for (int i = 0; i < NC; i++) data[i] = 8'($urandom) | 8'h01;
    apply_data();
    settle();
    repeat ($urandom_range(0, 200)) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pcm_vld = '0;
    checks++;
    if (pwm_out !== '0 || underrun !== '0 || sample_tick !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: pwm=%h underrun=%h tick=%b, need all 0",
               pwm_out, underrun, sample_tick);
    end
    wait_tick(k);
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL midrun_tick_restart: got %0d, need 3", k);
    end
    for (int i = 0; i < NC; i++) voice[i] = 8'h80;
    settle();
    measure();
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (duty[i] !== 128) begin
        errors++;
        $display("FAIL midrun_midscale ch%0d: got %0d, need 128", i, duty[i]);
      end
    end
    checks++;
    if (underrun !== 8'hFF) begin
      errors++;
      $display("FAIL midrun_underrun: got %h, need ff", underrun);
    end
  endtask

  initial begin
    test_reset();
    test_tick_period();
    test_capture_pwm();
    test_underrun();
    test_mix_mode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bytebeat_voice_mixer.md
Name: bytebeat_voice_mixer

Overview:
- Parametrised N-channel audio back end for the bytebeat generators.
- Replaces the per-top clock divider and fixed per-channel PWM with three pieces: a programmable sample-rate tick, a valid/ready sample capture per channel, and a selectable output mode (per-channel PWM or mixed mono PWM).
- Generators run on clk and use sample_tick as a clock enable; no derived clocks.
- Sits between the generator array and uo_out.

Parameters:
- NUM_CH, 8, number of voices; must be a power of 2, 1..8.
- SAMPLE_W, 8, PCM sample width.
- PWM_W, 8, PWM resolution; PWM_W <= SAMPLE_W; top PWM_W bits of a sample are used.
- DIV_W, 9, width of the sample-rate divider.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick_div  in  DIV_W  sample period minus one, in clk cycles
- ch_en  in  NUM_CH  per-channel enable
- mix_mode  in  1  0 = independent PWM per channel; 1 = mixed mono on pwm_out[0]
- clr_status  in  1  one-cycle pulse, clears the underrun flags
- pcm_data  in  NUM_CH*SAMPLE_W  flattened samples; channel i at [i*SAMPLE_W +: SAMPLE_W]
- pcm_vld  in  NUM_CH  sample valid per channel
- pcm_rdy  out  NUM_CH  sample accept per channel
- sample_tick  out  1  one-cycle sample-rate strobe, also the generator enable
- pwm_out  out  NUM_CH  PWM audio outputs
- underrun  out  NUM_CH  sticky flag: channel was not valid at a tick

Behaviour:
- Reset state:
  - Reset is rst_n, synchronous, active-low; clock is clk.
  - Tick counter, PWM counter, pwm_out, underrun and sample_tick are all 0.
  - Sample registers and compare registers reset to the midscale constant SAMPLE_MID (0x80 for 8 bits).
  - Latched mode resets to 0.
- Tick generator:
  - tick_cnt counts 0..tick_div, then wraps to 0.
  - sample_tick is high in the cycle where tick_cnt == tick_div, giving period tick_div+1.
  - tick_div = 0 makes sample_tick constantly high.
  - If tick_div changes below the current tick_cnt, the counter wraps at its natural overflow. No extra tick is generated.
- Capture:
  - pcm_rdy[i] = sample_tick & ch_en[i], combinational.
  - If pcm_vld[i] & pcm_rdy[i], sample_reg[i] takes channel i's data on the next edge.
  - If a channel is enabled, sample_tick is high and pcm_vld[i] is low: sample_reg[i] holds its value and underrun[i] is set.
  - A disabled channel forces sample_reg[i] to SAMPLE_MID on each tick; it is never flagged.
- Status:
  - clr_status clears all underrun bits.
  - If a clear and a new underrun occur in the same cycle, set wins.
- Mixer (registered):
  - The mix register updates one cycle after any capture edge.
  - mix = (sum over all NUM_CH of sample_reg) >> log2(NUM_CH).
  - The sum is SAMPLE_W+log2(NUM_CH) bits wide, so it has no overflow.
  - Disabled channels contribute SAMPLE_MID, so silence stays centred.
  - NUM_CH = 1 gives mix = sample_reg[0].
- PWM:
  - A free-running PWM_W-bit counter pwm_cnt wraps at 2^PWM_W-1.
  - At the wrap edge (pwm_cnt == all-ones), mix_mode is latched and all compare registers load. This makes changes glitch-free.
  - Latched mode 0: cmp[i] = top PWM_W bits of sample_reg[i].
  - Latched mode 1: cmp[0] = top bits of mix, and cmp[i>0] = 0.
  - pwm_out[i] is registered: pwm_out[i] <= (pwm_cnt < cmp[i]).
  - cmp = 0 gives a constant low output; cmp = max gives high for 2^PWM_W-1 of 2^PWM_W cycles.
- Latency:
  - Data accepted at tick cycle T is in sample_reg at T+1 and in mix at T+2.
  - It reaches cmp at the first PWM wrap after that, and pwm_out one cycle later.
- Reset mid-operation: every counter and register returns to its reset value on the next edge. Pending captures are dropped.

Decomposition:
- Package bytebeat_pkg holds:
  - SAMPLE_MID, computed as 1 << (SAMPLE_W-1);
  - the mix_mode_t enum {MIX_INDEP, MIX_MONO};
  - the helper function clog2_ch.
- Sub-module pwm_cmp_slice: one compare register plus its registered output. It takes the shared pwm_cnt, a load strobe and a value. Instantiate it NUM_CH times in a generate loop.

Test Plan:
- Tick period: tick_div = 3 → sample_tick high every 4th cycle. Then tick_div = 0 → sample_tick high every cycle.
- Capture and PWM: NUM_CH = 8, mode 0, ch_en = 0xFF, ch0 data = 0x40 held valid → after the next PWM wrap, pwm_out[0] is high for exactly 64 of 256 cycles. Data 0x00 → always low; data 0xFF → high 255/256.
- Underrun: ch_en[3] = 1 with pcm_vld[3] = 0 at a tick → underrun[3] = 1 and sample_reg[3] unchanged. clr_status and a new underrun in the same cycle → flag stays 1. clr_status alone → 0.
- Mix mode:
  - mode 1, ch0 = 0xFF, other seven channels disabled → mix = (0xFF + 7*0x80) >> 3 = 0x8F;
  - pwm_out[0] duty is 143/256 and pwm_out[7:1] are 0;
  - toggling mix_mode mid-period has no effect until the next wrap.
- Reset mid-operation: assert rst_n = 0 for 1 cycle mid-PWM period → all outputs are 0 next cycle, samples read SAMPLE_MID, and the tick restarts from 0.
